// File: rtl/lupa_frame_gen.sv
// LUPA-style sensor frame generator: produces FRAME_VALID / LINE_VALID timing
// and a selectable test pattern on DATA_IMAGE. All outputs come straight from
// registers. The pattern is chosen when a frame starts and cannot change until
// the next frame.
module lupa_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 32,
    parameter int V_ACTIVE = 480,
    parameter int FV_LEAD  = 8,
    parameter int FV_TAIL  = 8,
    parameter int V_BLANK  = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [1:0]  PATTERN_SEL,
    output logic [9:0]  DATA_IMAGE,
    output logic        LINE_VALID,
    output logic        FRAME_VALID,
    output logic        FRAME_DONE,
    output logic [15:0] FRAME_CNT,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        ACTIVE,
        HBLANK,
        TAIL,
        VBLANK
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [15:0] col_q;
    logic [15:0] row_q;
    logic [9:0]  lfsr_q;
    logic [9:0]  lfsrStep_d;
    logic [1:0]  patSel_q;
    logic [9:0]  data_q;
    logic        lv_q;
    logic        fv_q;
    logic        done_q;
    logic        busy_q;
    logic [15:0] frameCnt_q;

    // Pixel value for a given column/row. Only the low 10 bits of the
    // coordinates reach the image; the LFSR value is supplied by the caller
    // because it depends on where in the frame the pixel falls.
    function automatic logic [9:0] pixel(input logic [1:0]  sel,
                                         input logic [15:0] col,
                                         input logic [15:0] row,
                                         input logic [9:0]  lfsr);
        logic [9:0] value;
        value = 10'h000;
        unique case (sel)
            2'd0: value = col[9:0];
            2'd1: value = row[9:0];
            2'd2: value = (col[5] ^ row[5]) ? 10'h3FF : 10'h000;
            2'd3: value = lfsr;
        endcase
        return value;
    endfunction

    // Next LFSR state for x^10 + x^7 + 1, shifting towards the MSB.
    always_comb begin
        lfsrStep_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    // Frame timing FSM; every output is loaded alongside the state so that
    // it always describes the state the block is currently in.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            lfsr_q     <= 10'h001;
            patSel_q   <= '0;
            data_q     <= '0;
            lv_q       <= 1'b0;
            fv_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ENABLE) begin
                        state_q  <= LEAD;
                        cnt_q    <= '0;
                        patSel_q <= PATTERN_SEL;
                        lfsr_q   <= 10'h001;
                        fv_q     <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LEAD: begin
                    if (cnt_q == 32'(FV_LEAD - 1)) begin
                        state_q <= ACTIVE;
                        col_q   <= '0;
                        row_q   <= '0;
                        lv_q    <= 1'b1;
                        data_q  <= pixel(patSel_q, 16'd0, 16'd0, lfsr_q);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ACTIVE: begin
                    lfsr_q <= lfsrStep_d;
                    if (col_q == 16'(H_ACTIVE - 1)) begin
                        lv_q    <= 1'b0;
                        data_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= (row_q == 16'(V_ACTIVE - 1)) ? TAIL : HBLANK;
                    end else begin
                        col_q  <= col_q + 16'd1;
                        data_q <= pixel(patSel_q, col_q + 16'd1, row_q, lfsrStep_d);
                    end
                end
                HBLANK: begin
                    if (cnt_q == 32'(H_BLANK - 1)) begin
                        state_q <= ACTIVE;
                        col_q   <= '0;
                        row_q   <= row_q + 16'd1;
                        lv_q    <= 1'b1;
                        data_q  <= pixel(patSel_q, 16'd0, row_q + 16'd1, lfsr_q);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                TAIL: begin
                    if (cnt_q == 32'(FV_TAIL - 1)) begin
                        state_q    <= VBLANK;
                        cnt_q      <= '0;
                        fv_q       <= 1'b0;
                        done_q     <= 1'b1;
                        frameCnt_q <= frameCnt_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                VBLANK: begin
                    if (cnt_q == 32'(V_BLANK - 1)) begin
                        cnt_q <= '0;
                        if (ENABLE) begin
                            state_q  <= LEAD;
                            patSel_q <= PATTERN_SEL;
                            lfsr_q   <= 10'h001;
                            fv_q     <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fv_q    <= 1'b0;
                    lv_q    <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign DATA_IMAGE  = data_q;
    assign LINE_VALID  = lv_q;
    assign FRAME_VALID = fv_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_CNT   = frameCnt_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_lupa_frame_gen.sv
// Self-checking bench for lupa_frame_gen using a small frame geometry.
// Expected outputs come from a cycle-offset model of one frame: the offset
// since FRAME_VALID rose is split into lead / lines / tail / vblank with plain
// arithmetic, and the LFSR pattern is taken from the bit sequence
// s[n] = s[n-10] ^ s[n-7].
module tb_lupa_frame_gen;

    localparam int HA     = 4;
    localparam int HB     = 2;
    localparam int VA     = 3;
    localparam int LEAD   = 2;
    localparam int TAIL   = 2;
    localparam int VB     = 3;
    localparam int FVT    = LEAD + VA * HA + (VA - 1) * HB + TAIL;
    localparam int PERIOD = FVT + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [9:0]  DATA_IMAGE;
    logic        LINE_VALID;
    logic        FRAME_VALID;
    logic        FRAME_DONE;
    logic [15:0] FRAME_CNT;
    logic        BUSY;

    typedef struct packed {
        logic        fv;
        logic        lv;
        logic [9:0]  data;
        logic        done;
        logic        busy;
        logic [15:0] cnt;
    } obs_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] expCnt   = 16'h0000;
    logic        lfsrBits [0:63];

    always #5 clk = ~clk;

    lupa_frame_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .FV_LEAD  (LEAD),
        .FV_TAIL  (TAIL),
        .V_BLANK  (VB)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .ENABLE      (en),
        .PATTERN_SEL (sel),
        .DATA_IMAGE  (DATA_IMAGE),
        .LINE_VALID  (LINE_VALID),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_DONE  (FRAME_DONE),
        .FRAME_CNT   (FRAME_CNT),
        .BUSY        (BUSY)
    );

    // Snapshot of every DUT output, taken on the falling edge.
    function automatic obs_t observe();
        obs_t o;
        o.fv   = FRAME_VALID;
        o.lv   = LINE_VALID;
        o.data = DATA_IMAGE;
        o.done = FRAME_DONE;
        o.busy = BUSY;
        o.cnt  = FRAME_CNT;
        return o;
    endfunction

    // LFSR value shown for the k-th active pixel of a frame.
    function automatic logic [9:0] lfsrValue(int k);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = lfsrBits[k + 9 - i];
        return v;
    endfunction

    // Expected outputs t cycles after FRAME_VALID rose, for pattern s and a
    // completed-frame count of base before this frame.
    function automatic obs_t modelAt(int t, logic [1:0] s, logic [15:0] base);
        obs_t o;
        int   u;
        int   row;
        int   col;
        o      = '0;
        o.busy = 1'b1;
        o.cnt  = base;
        if (t < FVT) begin
            o.fv = 1'b1;
            if (t >= LEAD) begin
                u   = t - LEAD;
                row = u / (HA + HB);
                col = u % (HA + HB);
                if (row < VA && col < HA) begin
                    o.lv = 1'b1;
                    case (s)
                        2'd0: o.data = 10'(col);
                        2'd1: o.data = 10'(row);
                        2'd2: o.data = ((((col ^ row) >> 5) & 1) != 0) ? 10'h3FF : 10'h000;
                        default: o.data = lfsrValue(row * HA + col);
                    endcase
                end
            end
        end else begin
            o.cnt  = base + 16'd1;
            o.done = (t == FVT);
        end
        return o;
    endfunction

    // Drive the run request and pattern select for the next rising edge.
    task automatic applyStimulus(input logic enable, input logic [1:0] pattern);
        en  = enable;
        sel = pattern;
    endtask

    // Reset holds everything at zero even with ENABLE high.
    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        applyStimulus(1'b1, 2'd3);
        repeat (3) @(negedge clk);
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("[TB] FAIL reset_hold got=%h expected=%h", got, obs_t'(0));
        end
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0);
        expCnt = 16'h0000;
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("[TB] FAIL reset_release got=%h expected=%h", got, obs_t'(0));
        end
    endtask

    // One-cycle ENABLE pulse, column ramp, frame then back to IDLE.
    task automatic test_single_frame();
        obs_t got;
        obs_t exp;
        int   fvHigh = 0;
        int   lvRise = 0;
        logic lvPrev = 1'b0;
        applyStimulus(1'b1, 2'd0);
        @(negedge clk);
        for (int t = 0; t < PERIOD; t++) begin
            applyStimulus(1'b0, 2'($urandom_range(0, 3)));
            got = observe();
            exp = modelAt(t, 2'd0, expCnt);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL single_frame t=%0d got=%h expected=%h", t, got, exp);
            end
            fvHigh += int'(got.fv);
            if (got.lv && !lvPrev) lvRise++;
            lvPrev = got.lv;
            @(negedge clk);
        end
        expCnt = expCnt + 16'd1;
        checks++;
        if (fvHigh != 20) begin
            failures++;
            $display("[TB] FAIL single_fv_width got=%0d expected=20", fvHigh);
        end
        checks++;
        if (lvRise != 3) begin
            failures++;
            $display("[TB] FAIL single_lv_pulses got=%0d expected=3", lvRise);
        end
        for (int i = 0; i < 4; i++) begin
            got = observe();
            exp = '0;
            exp.cnt = expCnt;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL single_idle i=%0d got=%h expected=%h", i, got, exp);
            end
            @(negedge clk);
        end
    endtask

    // ENABLE held, row ramp: back-to-back frames with a fixed period.
    task automatic test_continuous();
        obs_t got;
        obs_t exp;
        int   rises [0:2];
        int   nRise = 0;
        int   cyc   = 0;
        logic fvPrev = 1'b0;
        applyStimulus(1'b1, 2'd1);
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < PERIOD; t++) begin
                if (f == 2 && t == 5) applyStimulus(1'b0, 2'd1);
                got = observe();
                exp = modelAt(t, 2'd1, expCnt);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL continuous f=%0d t=%0d got=%h expected=%h", f, t, got, exp);
                end
                if (got.fv && !fvPrev && nRise < 3) begin
                    rises[nRise] = cyc;
                    nRise++;
                end
                fvPrev = got.fv;
                cyc++;
                @(negedge clk);
            end
            expCnt = expCnt + 16'd1;
        end
        checks++;
        if (nRise != 3 || rises[1] - rises[0] != PERIOD || rises[2] - rises[1] != PERIOD) begin
            failures++;
            $display("[TB] FAIL continuous_period rises=%0d got=%0d,%0d expected=%0d", nRise,
                     rises[1] - rises[0], rises[2] - rises[1], PERIOD);
        end
    endtask

    // LFSR pattern over two frames: sequence must restart at 0x001.
    task automatic test_lfsr();
        obs_t got;
        obs_t exp;
        applyStimulus(1'b1, 2'd3);
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < PERIOD; t++) begin
                if (f == 1 && t == 3) applyStimulus(1'b0, 2'd0);
                got = observe();
                exp = modelAt(t, 2'd3, expCnt);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL lfsr f=%0d t=%0d got=%h expected=%h", f, t, got, exp);
                end
                if (t == LEAD) begin
                    checks++;
                    if (got.data !== 10'h001) begin
                        failures++;
                        $display("[TB] FAIL lfsr_seed f=%0d got=%h expected=001", f, got.data);
                    end
                end
                @(negedge clk);
            end
            expCnt = expCnt + 16'd1;
        end
    endtask

    // ENABLE dropped and pattern changed during row 1: frame finishes as a
    // column ramp, then the block stays idle.
    task automatic test_midframe_change();
        obs_t got;
        obs_t exp;
        applyStimulus(1'b1, 2'd0);
        @(negedge clk);
        for (int t = 0; t < PERIOD; t++) begin
            if (t == LEAD + HA + HB + 1) applyStimulus(1'b0, 2'd1);
            got = observe();
            exp = modelAt(t, 2'd0, expCnt);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL midframe t=%0d got=%h expected=%h", t, got, exp);
            end
            @(negedge clk);
        end
        expCnt = expCnt + 16'd1;
        for (int i = 0; i < 6; i++) begin
            got = observe();
            exp = '0;
            exp.cnt = expCnt;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL midframe_idle i=%0d got=%h expected=%h", i, got, exp);
            end
            @(negedge clk);
        end
    endtask

    // Reset during row 1 aborts the frame with no FRAME_DONE.
    task automatic test_reset_midframe();
        obs_t       got;
        obs_t       exp;
        logic [1:0] s;
        s = 2'($urandom_range(0, 3));
        applyStimulus(1'b1, s);
        @(negedge clk);
        for (int t = 0; t <= LEAD + HA + HB; t++) begin
            got = observe();
            exp = modelAt(t, s, expCnt);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL pre_reset t=%0d got=%h expected=%h", t, got, exp);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, s);
        expCnt = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            got = observe();
            checks++;
            if (got !== obs_t'(0)) begin
                failures++;
                $display("[TB] FAIL reset_midframe i=%0d got=%h expected=%h", i, got, obs_t'(0));
            end
            @(negedge clk);
        end
    endtask

    // Frame counter preset to 0xFFFF must wrap to 0 on the next frame.
    task automatic test_counter_wrap();
        obs_t       got;
        obs_t       exp;
        logic [1:0] s;
        force dut.frameCnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frameCnt_q;
        expCnt = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (FRAME_CNT !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL wrap_preset got=%h expected=ffff", FRAME_CNT);
        end
        s = 2'($urandom_range(0, 3));
        applyStimulus(1'b1, s);
        @(negedge clk);
        applyStimulus(1'b0, s);
        for (int t = 0; t < PERIOD; t++) begin
            got = observe();
            exp = modelAt(t, s, expCnt);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL wrap t=%0d got=%h expected=%h", t, got, exp);
            end
            @(negedge clk);
        end
        expCnt = expCnt + 16'd1;
        checks++;
        if (FRAME_CNT !== 16'h0000 || expCnt !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL wrap_final got=%h expected=0000", FRAME_CNT);
        end
    endtask

    // Random patterns, random mid-frame noise on ENABLE/PATTERN_SEL, and a
    // random decision at each frame end whether to continue or go idle.
    task automatic test_random();
        obs_t       got;
        obs_t       exp;
        logic [1:0] curSel;
        logic [1:0] nextSel;
        logic       cont;
        curSel = 2'($urandom_range(0, 3));
        applyStimulus(1'b1, curSel);
        @(negedge clk);
        for (int f = 0; f < 8; f++) begin
            cont    = 1'b0;
            nextSel = 2'($urandom_range(0, 3));
            for (int t = 0; t < PERIOD; t++) begin
                if (t < PERIOD - 1) begin
                    applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                end else begin
                    cont = (f < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
                    applyStimulus(cont, nextSel);
                end
                got = observe();
                exp = modelAt(t, curSel, expCnt);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL random f=%0d t=%0d sel=%0d got=%h expected=%h", f, t, curSel, got, exp);
                end
                @(negedge clk);
            end
            expCnt = expCnt + 16'd1;
            if (!cont) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    applyStimulus(1'b0, 2'($urandom_range(0, 3)));
                    got = observe();
                    exp = '0;
                    exp.cnt = expCnt;
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("[TB] FAIL random_idle f=%0d got=%h expected=%h", f, got, exp);
                    end
                    @(negedge clk);
                end
                if (f < 7) begin
                    applyStimulus(1'b1, nextSel);
                    @(negedge clk);
                end
            end
            curSel = nextSel;
        end
    endtask

    // Build the LFSR bit sequence, then run every scenario in order.
    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sel = 2'd0;
        for (int n = 0; n < 64; n++) begin
            if (n < 9)       lfsrBits[n] = 1'b0;
            else if (n == 9) lfsrBits[n] = 1'b1;
            else             lfsrBits[n] = lfsrBits[n - 10] ^ lfsrBits[n - 7];
        end
        test_reset();
        test_single_frame();
        test_continuous();
        test_lfsr();
        test_midframe_change();
        test_reset_midframe();
        test_counter_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
